// File: rtl/sha1_ctrl.sv
// sha1_ctrl -- sequencing controller for an external combinational SHA-1
// round datapath.
//
// Collects one 512-bit block as 16 big-endian 32-bit words. It then walks
// the round datapath through rounds 0..79, one round per cycle, expanding
// the message schedule in place in a 16-entry circular buffer. Finally it
// adds the working state into the running hash H and pulses digest_valid.
//
// Ports
//   clk            in   1    clock, rising edge
//   rst            in   1    asynchronous active-high reset
//   first_block    in   1    sampled with word 0: 1 = start from H_INIT
//   word_in        in   32   message word, word 0 first
//   word_valid     in   1    word_in valid
//   word_ready     out  1    a word is accepted this cycle if valid
//   round_cv       out  160  working state {a,b,c,d,e} to datapath cv_in
//   round_w        out  32   schedule word W[t] to datapath w
//   round_num      out  7    round index t to datapath round
//   round_cv_next  in   160  datapath cv_out
//   digest         out  160  hash state H
//   digest_valid   out  1    one-cycle pulse after H is updated
//   busy           out  1    high while rounds or the final add are in progress
module sha1_ctrl #(
   parameter logic [159:0] H_INIT = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         first_block,
   input  logic [31:0]  word_in,
   input  logic         word_valid,
   output logic         word_ready,
   output logic [159:0] round_cv,
   output logic [31:0]  round_w,
   output logic [6:0]   round_num,
   input  logic [159:0] round_cv_next,
   output logic [159:0] digest,
   output logic         digest_valid,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;

   state_t         state, state_next;
   logic [3:0]     cnt;          // next word slot while loading
   logic           fb;           // first_block latched with word 0
   logic [6:0]     t;            // round counter
   logic [159:0]   work;         // working state {a,b,c,d,e}
   logic [159:0]   h;            // running hash state
   logic           dv;

   logic [31:0]    w_mem [16];   // circular schedule buffer
   logic           accept;
   logic [3:0]     t_lo;
   logic [31:0]    w_mix;
   logic [31:0]    w_new;
   logic           wr_en;
   logic [3:0]     wr_addr;
   logic [31:0]    wr_data;
   logic [159:0]   h_sum;

   assign word_ready   = (state == IDLE) || (state == LOAD);
   assign busy         = (state == ROUND) || (state == FINAL);
   assign accept       = word_valid && word_ready;
   assign digest       = h;
   assign digest_valid = dv;
   assign round_cv     = work;
   assign round_num    = (state == ROUND) ? t : 7'd0;

   // Schedule expansion over the circular buffer. Slot t&15 still holds
   // W[t-16]; the other taps are the 4-bit wrapped offsets -3, -8 and -14
   // (-14 mod 16 = +2).
   assign t_lo  = t[3:0];
   assign w_mix = w_mem[t_lo - 4'd3] ^ w_mem[t_lo - 4'd8] ^
                  w_mem[t_lo + 4'd2] ^ w_mem[t_lo];
   assign w_new = {w_mix[30:0], w_mix[31]};

   assign round_w = (t < 7'd16) ? w_mem[t_lo] : w_new;

   // Single write port: incoming words while loading, expanded words during
   // rounds 16..79 (each overwrites the slot it was derived from).
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = 4'd0;
      wr_data = word_in;
      case (state)
         IDLE: begin
            wr_en   = accept;
            wr_addr = 4'd0;
         end
         LOAD: begin
            wr_en   = accept;
            wr_addr = cnt;
         end
         ROUND: begin
            wr_en   = (t >= 7'd16);
            wr_addr = t_lo;
            wr_data = w_new;
         end
         default: ;
      endcase
   end

   // The buffer is always fully rewritten before it is read, so it needs
   // no reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         w_mem[wr_addr] <= wr_data;
   end

   // Per-word modular add of the working state into H; no carry between
   // the five 32-bit lanes.
   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_fold
         assign h_sum[gi*32 +: 32] = h[gi*32 +: 32] + work[gi*32 +: 32];
      end
   endgenerate

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (accept) state_next = LOAD;
         LOAD:  if (accept && cnt == 4'd15) state_next = ROUND;
         ROUND: if (t == 7'd79) state_next = FINAL;
         FINAL: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Counters, working state and hash state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= 4'd0;
         fb   <= 1'b0;
         t    <= 7'd0;
         work <= 160'd0;
         h    <= H_INIT;
         dv   <= 1'b0;
      end else begin
         dv <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  fb  <= first_block;
                  cnt <= 4'd1;
               end
            end
            LOAD: begin
               if (accept) begin
                  cnt <= cnt + 4'd1;   // wraps back to 0 after word 15
                  if (cnt == 4'd15) begin
                     work <= fb ? H_INIT : h;
                     if (fb)
                        h <= H_INIT;
                     t <= 7'd0;
                  end
               end
            end
            ROUND: begin
               work <= round_cv_next;
               t    <= t + 7'd1;
            end
            FINAL: begin
               h  <= h_sum;
               dv <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha1_ctrl.sv
// Testbench for sha1_ctrl. Supplies the SHA-1 round function as the external
// datapath, drives message blocks, and checks the round trace and digests.
module tb_sha1_ctrl;

   localparam logic [159:0] H0        = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;
   localparam logic [159:0] ABC_DIG   = 160'hA9993E364706816ABA3E25717850C26C9CD0D89D;
   localparam logic [159:0] EMPTY_DIG = 160'hDA39A3EE5E6B4B0D3255BFEF95601890AFD80709;
   localparam logic [159:0] TWO_DIG   = 160'h84983E441C3BD26EBAAE4AA1F95129E5E54670F1;

   localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [511:0] B1_BLK    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696A, 32'h68696A6B,
                                         32'h696A6B6C, 32'h6A6B6C6D, 32'h6B6C6D6E, 32'h6C6D6E6F,
                                         32'h6D6E6F70, 32'h6E6F7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] B2_BLK    = {480'h0, 32'h000001C0};

   logic         clk = 1'b0;
   logic         rst;
   logic         first_block;
   logic [31:0]  word_in;
   logic         word_valid;
   logic         word_ready;
   logic [159:0] round_cv;
   logic [31:0]  round_w;
   logic [6:0]   round_num;
   logic [159:0] round_cv_next;
   logic [159:0] digest;
   logic         digest_valid;
   logic         busy;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [159:0] sb [$];
   logic [31:0]  gw [80];

   always #5 clk = ~clk;

   sha1_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .first_block   (first_block),
      .word_in       (word_in),
      .word_valid    (word_valid),
      .word_ready    (word_ready),
      .round_cv      (round_cv),
      .round_w       (round_w),
      .round_num     (round_num),
      .round_cv_next (round_cv_next),
      .digest        (digest),
      .digest_valid  (digest_valid),
      .busy          (busy)
   );

   // SHA-1 round function (the external datapath)
   function automatic logic [159:0] round_fn(input logic [159:0] cv, input logic [31:0] w,
                                             input logic [6:0] tt);
      logic [31:0] a, b, c, d, e, f, k, tmp;
      a = cv[159:128]; b = cv[127:96]; c = cv[95:64]; d = cv[63:32]; e = cv[31:0];
      if (tt < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (tt < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (tt < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else              begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w;
      return {tmp, a, {b[1:0], b[31:2]}, c, d};
   endfunction

   assign round_cv_next = round_fn(round_cv, round_w, round_num);

   // Reference compression of one block onto hash state hin
   function automatic logic [159:0] compress(input logic [159:0] hin, input logic [511:0] blk);
      logic [31:0]  x [80];
      logic [31:0]  m;
      logic [159:0] cv;
      logic [159:0] r;
      for (int i = 0; i < 16; i++) x[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 80; i++) begin
         m = x[i-3] ^ x[i-8] ^ x[i-14] ^ x[i-16];
         x[i] = {m[30:0], m[31]};
      end
      cv = hin;
      for (int i = 0; i < 80; i++) cv = round_fn(cv, x[i], 7'(i));
      for (int i = 0; i < 5; i++) r[i*32 +: 32] = hin[i*32 +: 32] + cv[i*32 +: 32];
      return r;
   endfunction

   task automatic build_schedule(input logic [511:0] blk);
      logic [31:0] m;
      for (int i = 0; i < 16; i++) gw[i] = blk[511-32*i -: 32];
      for (int i = 16; i < 80; i++) begin
         m = gw[i-3] ^ gw[i-8] ^ gw[i-14] ^ gw[i-16];
         gw[i] = {m[30:0], m[31]};
      end
   endtask

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Enters and leaves at a falling edge. Drives the 16 words of blk; the
   // flag for first_block is only meaningful on word 0, so the other words
   // carry the opposite value.
   task automatic send_words(input logic [511:0] blk, input logic fb, input bit gaps,
                             input bit hold);
      for (int i = 0; i < 16; i++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            for (int j = 0; j < g; j++) begin
               word_valid = 1'b0;
               word_in    = $urandom;
               @(negedge clk);
            end
         end
         chk($sformatf("word_ready_w%0d", i), word_ready, 1'b1);
         word_valid  = 1'b1;
         word_in     = blk[511-32*i -: 32];
         first_block = (i == 0) ? fb : ~fb;
         @(negedge clk);
      end
      word_valid  = hold;
      word_in     = 32'hDEADBEEF;
      first_block = ~fb;
   endtask

   // Called at the first ROUND cycle. Follows the block cycle by cycle up to
   // the digest_valid cycle (leaves at that falling edge), or returns early
   // at round stop_at.
   task automatic run_block(input logic [511:0] blk, input string name, input int stop_at,
                            input bit chk16);
      int busy_cnt;
      busy_cnt = 0;
      build_schedule(blk);
      for (int t = 0; t < 80; t++) begin
         if (t == stop_at) return;
         chk($sformatf("%s_round_num_t%0d", name, t), round_num, 160'(t));
         chk($sformatf("%s_round_w_t%0d", name, t), round_w, gw[t]);
         if (chk16 && t == 16) chk($sformatf("%s_w16", name), round_w, 32'hC2C4C700);
         chk($sformatf("%s_ready_t%0d", name, t), word_ready, 1'b0);
         chk($sformatf("%s_dv_t%0d", name, t), digest_valid, 1'b0);
         if (busy === 1'b1) busy_cnt++;
         @(negedge clk);
      end
      chk($sformatf("%s_ready_final", name), word_ready, 1'b0);
      chk($sformatf("%s_dv_final", name), digest_valid, 1'b0);
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      chk($sformatf("%s_busy_after", name), busy, 1'b0);
      chk($sformatf("%s_busy_cycles", name), 160'(busy_cnt), 160'd81);
      chk($sformatf("%s_dv_pulse", name), digest_valid, 1'b1);
      if (digest_valid === 1'b1 && sb.size() > 0)
         chk($sformatf("%s_digest", name), digest, sb.pop_front());
   endtask

   initial begin
      int pulses;
      rst         = 1'b1;
      word_valid  = 1'b0;
      word_in     = 32'h0;
      first_block = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_digest", digest, H0);
      chk("rst_dv", digest_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", word_ready, 1'b1);
      chk("rst_round_num", round_num, 7'd0);
      rst = 1'b0;
      @(negedge clk);

      // "abc", with the round trace
      sb.push_back(ABC_DIG);
      send_words(ABC_BLK, 1'b1, 1'b0, 1'b0);
      run_block(ABC_BLK, "abc", 80, 1'b1);
      @(negedge clk);
      chk("abc_dv_drop", digest_valid, 1'b0);
      chk("abc_digest_hold", digest, ABC_DIG);

      // Empty message: first_block=1 must restart from H_INIT
      sb.push_back(EMPTY_DIG);
      send_words(EMPTY_BLK, 1'b1, 1'b0, 1'b0);
      run_block(EMPTY_BLK, "empty", 80, 1'b0);

      // Two blocks, second one starting in the digest_valid cycle
      sb.push_back(compress(H0, B1_BLK));
      send_words(B1_BLK, 1'b1, 1'b0, 1'b0);
      run_block(B1_BLK, "two_b1", 80, 1'b0);
      sb.push_back(TWO_DIG);
      send_words(B2_BLK, 1'b0, 1'b0, 1'b0);
      run_block(B2_BLK, "two_b2", 80, 1'b0);
      word_valid = 1'b0;
      @(negedge clk);

      // Gaps while loading, word_valid held high through the rounds
      sb.push_back(ABC_DIG);
      send_words(ABC_BLK, 1'b1, 1'b1, 1'b1);
      run_block(ABC_BLK, "bp", 80, 1'b0);
      word_valid = 1'b0;
      @(negedge clk);

      // Stray words after a block leave the digest alone; then reset in LOAD
      for (int i = 0; i < 5; i++) begin
         word_valid = 1'b1;
         word_in    = $urandom;
         @(negedge clk);
      end
      word_valid = 1'b0;
      chk("junk_digest_hold", digest, ABC_DIG);
      chk("junk_dv", digest_valid, 1'b0);
      rst = 1'b1;
      #1;
      chk("rst_load_digest", digest, H0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset at round 40, then "abc" with first_block=0 after reset
      sb.push_back(ABC_DIG);
      send_words(ABC_BLK, 1'b1, 1'b0, 1'b0);
      run_block(ABC_BLK, "rst40", 40, 1'b0);
      chk("rst40_at40", round_num, 7'd40);
      #2 rst = 1'b1;
      #1;
      chk("rst40_busy", busy, 1'b0);
      chk("rst40_ready", word_ready, 1'b1);
      chk("rst40_digest", digest, H0);
      chk("rst40_dv", digest_valid, 1'b0);
      chk("rst40_round_num", round_num, 7'd0);
      sb.delete();
      @(negedge clk);
      rst        = 1'b0;
      word_valid = 1'b0;
      pulses     = 0;
      for (int i = 0; i < 100; i++) begin
         if (digest_valid !== 1'b0 || busy !== 1'b0) pulses++;
         @(negedge clk);
      end
      chk("rst40_quiet", 160'(pulses), 160'd0);
      chk("rst40_digest_quiet", digest, H0);
      sb.push_back(ABC_DIG);
      send_words(ABC_BLK, 1'b0, 1'b0, 1'b0);
      run_block(ABC_BLK, "post_rst", 80, 1'b0);
      word_valid = 1'b0;

      chk("sb_empty", 160'(sb.size()), 160'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sha1_ctrl.md
Name: sha1_ctrl

Overview:
Sequencing controller for the combinational SHA-1 round datapath (cv_in/w/round -> cv_out).
- Accepts a 512-bit message block as 16 serial 32-bit words over a valid/ready handshake.
- Expands the message schedule in a 16-entry circular buffer and drives the round datapath for 80 cycles, one round per cycle.
- Folds the result into the running 160-bit hash state and presents the digest.
- Sits between the message padder/feeder and the digest consumer; the round datapath lives outside this block and is wired by the parent.

Parameters:
H_INIT, 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0, initial chaining value {H0,H1,H2,H3,H4}

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
first_block  in  1  sampled with word 0 of a block: 1 = start from H_INIT, 0 = chain from current digest
word_in  in  32  message word, big-endian, word 0 first
word_valid  in  1  word_in valid
word_ready  out  1  controller accepts a word this cycle
round_cv  out  160  working state {a,b,c,d,e} to round datapath cv_in
round_w  out  32  schedule word W[t] to round datapath w
round_num  out  7  round index t (0..79) to round datapath round
round_cv_next  in  160  round datapath cv_out
digest  out  160  hash state H, updated after each block
digest_valid  out  1  one-cycle pulse: digest just updated
busy  out  1  high in ROUND and FINAL

Behaviour:
- Reset (async, immediate):
  - state=IDLE; H=H_INIT, so digest=H_INIT.
  - digest_valid=0, busy=0, word counter=0, round counter=0, working register=0.
- States: IDLE, LOAD, ROUND, FINAL.
- Acceptance: a word is accepted on any edge where word_valid && word_ready. word_ready=1 in IDLE and LOAD, 0 in ROUND and FINAL. word_valid outside IDLE/LOAD is ignored; no buffering.
- IDLE:
  - On accept, write W[0], latch first_block, set cnt=1, go to LOAD.
  - Idle cycles with word_valid=0 are allowed anywhere in IDLE/LOAD; gaps between words are legal.
- LOAD:
  - Each accept writes W[cnt] and increments cnt.
  - On accepting word 15 (edge E0): working register <= (latched first_block ? H_INIT : H); also H <= H_INIT when first_block=1. Set t=0, go to ROUND.
- ROUND:
  - round_num=t and round_cv=working register.
  - round_w: if t<16, W[t]; else rotl1(W[(t-3)&15] ^ W[(t-8)&15] ^ W[(t-14)&15] ^ W[t&15]).
  - When t>=16, the computed word is written back to slot t&15 on the same edge.
  - Each edge: working register <= round_cv_next, t <= t+1.
  - After round 79 (edge E80), go to FINAL.
  - round_num, round_cv and round_w are don't-care outside ROUND; drive round_num=0.
- FINAL (one cycle): on edge E81, H[i] <= H[i] + working[i] for each 32-bit word, mod 2^32 with no carry between words. Set digest_valid=1 and go to IDLE.
- digest_valid is high for exactly the one cycle after E81. The next block's word 0 may be accepted in that same cycle.
- Latency: 16th-word accept to digest_valid high = 81 edges. Throughput: one block per 16+81 cycles minimum.
- digest holds its value until the next FINAL or reset; it is unaffected by word input.
- Reset mid-block (LOAD/ROUND/FINAL): block is abandoned, all state returns to reset values. No partial digest update; digest=H_INIT.
- first_block=0 after reset with no prior block: chains from H_INIT, identical to first_block=1.

Test Plan:
- "abc" single block: words 61626380, 00000000 x14, 00000018, first_block=1 -> digest_valid pulse 81 edges after last word; digest=A9993E36 4706816A BA3E2571 7850C26C 9CD0D89D.
- Empty message: 80000000, then 15 zero words -> digest=DA39A3EE 5E6B4B0D 3255BFEF 95601890 AFD80709.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmjklmnklmnlmnomnopnopq" (block 2: first_block=0), word 0 of block 2 sent in the digest_valid cycle -> final digest=84983E44 1C3BD26E BAAE4AA1 F95129E5 E54670F1; intermediate digest_valid pulse also checked.
- Backpressure and gaps: random word_valid gaps during LOAD; word_valid held high during ROUND -> word_ready=0 throughout ROUND/FINAL, extra words not consumed, busy high for exactly 81 cycles, "abc" digest unchanged.
- round_num/round_w trace for "abc": round_num steps 0..79 one per cycle; round_w at t=16 is 0xC2C4C700 (rotl1(W13^W8^W2^W0) = rotl1(0x61626380)), with all other W[t] for t>=16 matching the golden model.
- Assert rst at t=40 of a block -> immediately state=IDLE, busy=0, digest=H_INIT, no digest_valid pulse; a subsequent "abc" block yields the correct digest.
